morse_rx: RTL and testbench
===========================

# morse_rx

Morse keyer receiver: the decode-side counterpart of the transmitter's element timing counter. It samples a raw key input, debounces it, and measures mark and space durations in time units using an internal prescaler. It classifies each mark as a dot or a dash, assembles elements into a character code, and flags character ends, word gaps and malformed input. It sits between a GPIO key pin and the processor's memory-mapped peripheral logic, which consumes `char_valid_o` strobes.

## Interface
- `UNIT_CYCLES`, default 1200000: clock cycles per Morse time unit (100 ms at 12 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronized samples required before the filtered key changes; must be ≥ 1.
- `DASH_UNITS`, default 2: a mark of this many whole units or more is a dash.
- `CHAR_GAP_UNITS`, default 2: a space of this many units ends a character.
- `WORD_GAP_UNITS`, default 5: a space of this many units signals a word gap; must be > `CHAR_GAP_UNITS`.
- `MAX_MARK_UNITS`, default 7: a mark that reaches `MAX_MARK_UNITS+1` units is an error.
- `clk_i`, input, 1: clock.
- `rstn_i`, input, 1: reset, asynchronous, active-low.
- `key_i`, input, 1: raw key, asynchronous to `clk_i`; 1 = key down.
- `char_valid_o`, output, 1: one-cycle strobe; `char_len_o`/`char_bits_o` are valid in that cycle.
- `char_len_o`, output, 3: number of elements, 1..6.
- `char_bits_o`, output, 6: element k in bit k (bit0 = first element), 1 = dash, 0 = dot; bits ≥ `char_len_o` are 0.
- `word_gap_o`, output, 1: one-cycle strobe on word gap.
- `error_o`, output, 1: one-cycle strobe on an overlong mark or more than 6 elements.
- `busy_o`, output, 1: high whenever state ≠ IDLE.

## Operation
- **Input path:** 2-flop synchronizer, then debounce counter. The filtered key `key_f` takes the synchronized value after `DEBOUNCE_CYCLES` consecutive equal samples that differ from `key_f`. Any disagreeing sample restarts the count.
- **Prescaler:** counts 0..`UNIT_CYCLES-1` and wraps. It is cleared on every `key_f` edge.
  - On each wrap, `unit_cnt` increments.
  - `unit_cnt` is 4 bits, saturates at 15, and is cleared on every `key_f` edge.
- **State IDLE:** no pending elements.
  - `key_f` rise → MARK.
- **State MARK:**
  - `key_f` fall with `unit_cnt < DASH_UNITS` → append a dot. `key_f` fall otherwise → append a dash. Then go to SPACE.
  - If the appended element would be the 7th → `error_o` pulses, the shift register and count are cleared, and the state becomes WAIT_WORD.
  - `unit_cnt` reaching `MAX_MARK_UNITS+1` while in MARK → `error_o` pulses, the buffer is cleared, and the state becomes DRAIN.
- **State SPACE:**
  - `key_f` rise → MARK.
  - `unit_cnt` reaching `CHAR_GAP_UNITS` → `char_valid_o` pulses with the buffered code, the buffer clears, and the state becomes WAIT_WORD.
- **State WAIT_WORD:**
  - `key_f` rise → MARK, with no `word_gap_o`.
  - `unit_cnt` reaching `WORD_GAP_UNITS` → `word_gap_o` pulses, then IDLE.
- **State DRAIN:** ignores the key until `key_f` falls, then → WAIT_WORD. An error is never followed by `char_valid_o` for the discarded elements.
- **Simultaneous events:**
  - A `key_f` edge in the same cycle as a threshold wrap: the edge wins. The threshold event is not taken and counting restarts.
  - `unit_cnt` thresholds are compared against the post-increment value.
- **Reset:** asserting `rstn_i` at any time, including mid-mark, immediately clears all state.
  - All outputs go to 0, state becomes IDLE, and `key_f` = 0.
  - Synchronizer flops, debounce counter, prescaler, `unit_cnt` and the element buffer are all reset to 0.

## Timing
- Raw key edge to `key_f` edge: 2 + `DEBOUNCE_CYCLES` cycles for a clean edge.
- Element classification is registered in the cycle after the `key_f` fall.
- `char_valid_o`, `word_gap_o` and `error_o` are registered. Each goes high in the cycle after the prescaler wrap that produces the threshold value, and lasts exactly one cycle.
- Space measured to `char_valid_o`: `CHAR_GAP_UNITS`×`UNIT_CYCLES` + 1 cycles after the `key_f` fall.
- `char_len_o`/`char_bits_o` hold their value until the next `char_valid_o`. Their reset value is 0.
- At most one of the three strobes is high in any cycle.

## Test plan
Bench parameters: `UNIT_CYCLES`=4, `DEBOUNCE_CYCLES`=2, other parameters at default.
- **Letter "A":** key down 1 unit, up 1 unit, down 3 units, up 6 units → one `char_valid_o` with `char_len_o`=2 and `char_bits_o`=6'b000010. Then `word_gap_o` fires 3 units after `char_valid_o`. `busy_o` = 0 afterwards.
- **Glitch rejection:** 1-cycle key pulses every 5 cycles while up, and 1-cycle drops during a 3-unit mark → `key_f` is unaffected; exactly one dash is recorded.
- **Overlong mark:** key down 10 units, then up 6 units → `error_o` fires once, 8 units after `key_f` rise. No `char_valid_o`. One `word_gap_o` fires 5 units after release.
- **Overflow:** 7 dots with 1-unit spaces → `error_o` fires at the 7th release. No `char_valid_o` for the sequence.
- **Back-to-back:** "E" (1 dot) with a 2-unit space, then "T" (1 dash) → `char_valid_o` with len 1, bits 0, then len 1, bits 1. No `word_gap_o` between them.
- **Reset mid-mark:** pulse `rstn_i` low during a 3-unit mark → all outputs are 0 immediately. The next clean "E" decodes correctly.

Source files
------------

// File: rtl/morse_rx.sv
// -----------------------------------------------------------------------------
// morse_rx
//
// Morse keyer receiver. The raw key pin is synchronized and debounced, and
// mark/space durations are measured in Morse time units by a prescaler and a
// saturating unit counter. Marks are classified as dots or dashes and collected
// into a character code. The block flags character ends, word gaps and
// malformed input (overlong marks, more than six elements).
//
// Ports
//   clk_i        : clock
//   rstn_i       : asynchronous active-low reset
//   key_i        : raw key, asynchronous to clk_i, 1 = key down
//   char_valid_o : one-cycle strobe, char_len_o/char_bits_o valid with it
//   char_len_o   : element count of the last character (1..6), held
//   char_bits_o  : element k in bit k, 1 = dash, 0 = dot, held
//   word_gap_o   : one-cycle strobe on a word gap
//   error_o      : one-cycle strobe on an overlong mark or a 7th element
//   busy_o       : receiver is not idle
// -----------------------------------------------------------------------------
module morse_rx #(
    parameter int UNIT_CYCLES     = 1200000,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DASH_UNITS      = 2,
    parameter int CHAR_GAP_UNITS  = 2,
    parameter int WORD_GAP_UNITS  = 5,
    parameter int MAX_MARK_UNITS  = 7
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       key_i,
    output logic       char_valid_o,
    output logic [2:0] char_len_o,
    output logic [5:0] char_bits_o,
    output logic       word_gap_o,
    output logic       error_o,
    output logic       busy_o
);

    localparam int PRE_W = $clog2(UNIT_CYCLES);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       DASH_U   = 4'(DASH_UNITS);
    localparam logic [3:0]       CHAR_U   = 4'(CHAR_GAP_UNITS);
    localparam logic [3:0]       WORD_U   = 4'(WORD_GAP_UNITS);
    localparam logic [3:0]       OVER_U   = 4'(MAX_MARK_UNITS + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MARK      = 3'd1,
        SPACE     = 3'd2,
        WAIT_WORD = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchronizer and debounce filter
    // ------------------------------------------------------------------
    logic            sync1_reg;
    logic            sync2_reg;
    logic            key_f_reg;
    logic            key_f_d_reg;
    logic [DB_W-1:0] db_cnt_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            key_f_reg   <= 1'b0;
            key_f_d_reg <= 1'b0;
            db_cnt_reg  <= '0;
        end else begin
            sync1_reg   <= key_i;
            sync2_reg   <= sync1_reg;
            key_f_d_reg <= key_f_reg;
            // A sample that agrees with the filtered key restarts the count.
            if (sync2_reg == key_f_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                key_f_reg  <= sync2_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    logic key_rise;
    logic key_fall;
    logic key_edge;

    assign key_rise = key_f_reg & ~key_f_d_reg;
    assign key_fall = ~key_f_reg & key_f_d_reg;
    assign key_edge = key_rise | key_fall;

    // ------------------------------------------------------------------
    // Prescaler and unit counter, both restarted on every filtered edge
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt_reg;
    logic [3:0]       unit_cnt_reg;
    logic [3:0]       unit_inc;
    logic             wrap;

    assign wrap     = (pre_cnt_reg == PRE_LAST);
    assign unit_inc = (unit_cnt_reg == 4'd15) ? 4'd15 : unit_cnt_reg + 4'd1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pre_cnt_reg  <= '0;
            unit_cnt_reg <= '0;
        end else if (key_edge) begin
            pre_cnt_reg  <= '0;
            unit_cnt_reg <= '0;
        end else if (wrap) begin
            pre_cnt_reg  <= '0;
            unit_cnt_reg <= unit_inc;
        end else begin
            pre_cnt_reg  <= pre_cnt_reg + 1'b1;
        end
    end

    // Threshold events fire only on a real increment not pre-empted by an
    // edge; the saturated value at 15 never re-triggers.
    logic unit_step;
    logic reach_char;
    logic reach_word;
    logic reach_over;

    assign unit_step  = wrap & ~key_edge & (unit_inc != unit_cnt_reg);
    assign reach_char = unit_step & (unit_inc == CHAR_U);
    assign reach_word = unit_step & (unit_inc == WORD_U);
    assign reach_over = unit_step & (unit_inc == OVER_U);

    // Mark length includes the unit that completes in the fall cycle, so a
    // mark of exactly DASH_UNITS units is classified as a dash.
    logic [3:0] mark_units;
    logic       is_dash;

    assign mark_units = wrap ? unit_inc : unit_cnt_reg;
    assign is_dash    = (mark_units >= DASH_U);

    // ------------------------------------------------------------------
    // Element buffer slot selection (one-hot position of the next element)
    // ------------------------------------------------------------------
    logic [2:0] buf_len_reg;
    logic [5:0] buf_bits_reg;
    logic [5:0] elem_mask;

    for (genvar gi = 0; gi < 6; gi++) begin : g_elem
        assign elem_mask[gi] = (buf_len_reg == 3'(gi));
    end

    // ------------------------------------------------------------------
    // Decode FSM
    // ------------------------------------------------------------------
    state_t     state_reg;
    state_t     state_next;
    logic [2:0] buf_len_next;
    logic [5:0] buf_bits_next;
    logic       char_valid_reg;
    logic       char_valid_next;
    logic [2:0] char_len_reg;
    logic [2:0] char_len_next;
    logic [5:0] char_bits_reg;
    logic [5:0] char_bits_next;
    logic       word_gap_reg;
    logic       word_gap_next;
    logic       error_reg;
    logic       error_next;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg      <= IDLE;
            buf_len_reg    <= '0;
            buf_bits_reg   <= '0;
            char_valid_reg <= 1'b0;
            char_len_reg   <= '0;
            char_bits_reg  <= '0;
            word_gap_reg   <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            buf_len_reg    <= buf_len_next;
            buf_bits_reg   <= buf_bits_next;
            char_valid_reg <= char_valid_next;
            char_len_reg   <= char_len_next;
            char_bits_reg  <= char_bits_next;
            word_gap_reg   <= word_gap_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        buf_len_next    = buf_len_reg;
        buf_bits_next   = buf_bits_reg;
        char_valid_next = 1'b0;
        char_len_next   = char_len_reg;
        char_bits_next  = char_bits_reg;
        word_gap_next   = 1'b0;
        error_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (key_rise) begin
                    state_next = MARK;
                end
            end

            MARK: begin
                if (key_fall) begin
                    if (buf_len_reg == 3'd6) begin
                        // Seventh element: discard the whole character.
                        error_next    = 1'b1;
                        buf_len_next  = '0;
                        buf_bits_next = '0;
                        state_next    = WAIT_WORD;
                    end else begin
                        buf_bits_next = buf_bits_reg | (elem_mask & {6{is_dash}});
                        buf_len_next  = buf_len_reg + 3'd1;
                        state_next    = SPACE;
                    end
                end else if (reach_over) begin
                    error_next    = 1'b1;
                    buf_len_next  = '0;
                    buf_bits_next = '0;
                    state_next    = DRAIN;
                end
            end

            SPACE: begin
                if (key_rise) begin
                    state_next = MARK;
                end else if (reach_char) begin
                    char_valid_next = 1'b1;
                    char_len_next   = buf_len_reg;
                    char_bits_next  = buf_bits_reg;
                    buf_len_next    = '0;
                    buf_bits_next   = '0;
                    state_next      = WAIT_WORD;
                end
            end

            WAIT_WORD: begin
                if (key_rise) begin
                    state_next = MARK;
                end else if (reach_word) begin
                    word_gap_next = 1'b1;
                    state_next    = IDLE;
                end
            end

            DRAIN: begin
                // Unit counter restarts on this fall, so the word gap is
                // measured from the release of the overlong mark.
                if (key_fall) begin
                    state_next = WAIT_WORD;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign char_valid_o = char_valid_reg;
    assign char_len_o   = char_len_reg;
    assign char_bits_o  = char_bits_reg;
    assign word_gap_o   = word_gap_reg;
    assign error_o      = error_reg;
    assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_morse_rx.sv
// -----------------------------------------------------------------------------
// tb_morse_rx
//
// Directed self-checking bench for morse_rx with UNIT_CYCLES=4 and
// DEBOUNCE_CYCLES=2. Inputs change on the falling clock edge; outputs are
// sampled on the falling edge. A raw key change applied when the posedge
// counter reads P reaches the filtered key at posedge P+4, the edge is seen
// at posedge P+5, and a strobe after n whole units is visible at cycle
// P+5+4n.
// -----------------------------------------------------------------------------
module tb_morse_rx;

    logic       clk_i;
    logic       rstn_i;
    logic       key_i;
    logic       char_valid_o;
    logic [2:0] char_len_o;
    logic [5:0] char_bits_o;
    logic       word_gap_o;
    logic       error_o;
    logic       busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    morse_rx #(
        .UNIT_CYCLES     (4),
        .DEBOUNCE_CYCLES (2)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .key_i        (key_i),
        .char_valid_o (char_valid_o),
        .char_len_o   (char_len_o),
        .char_bits_o  (char_bits_o),
        .word_gap_o   (word_gap_o),
        .error_o      (error_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Posedge counter used to time-stamp strobes.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Strobe log, sampled on the falling edge.
    int       cv_n = 0;
    int       wg_n = 0;
    int       er_n = 0;
    int       excl_bad = 0;
    int       cv_cyc [64];
    logic [2:0] cv_len [64];
    logic [5:0] cv_bits[64];
    int       wg_cyc [64];
    int       er_cyc [64];

    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (char_valid_o) begin
                if (cv_n < 64) begin
                    cv_cyc[cv_n]  <= cyc;
                    cv_len[cv_n]  <= char_len_o;
                    cv_bits[cv_n] <= char_bits_o;
                end
                cv_n <= cv_n + 1;
            end
            if (word_gap_o) begin
                if (wg_n < 64) wg_cyc[wg_n] <= cyc;
                wg_n <= wg_n + 1;
            end
            if (error_o) begin
                if (er_n < 64) er_cyc[er_n] <= cyc;
                er_n <= er_n + 1;
            end
            if ((char_valid_o & word_gap_o) | (char_valid_o & error_o) | (word_gap_o & error_o))
                excl_bad <= excl_bad + 1;
        end
    end

    task automatic key_hold(input logic val, input int n);
        key_i = val;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        key_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        tests_run++; if (char_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_char_valid: got %0b expected 0", char_valid_o); end
        tests_run++; if (char_len_o !== 3'd0) begin tests_failed++; $display("FAIL reset_char_len: got %0d expected 0", char_len_o); end
        tests_run++; if (char_bits_o !== 6'd0) begin tests_failed++; $display("FAIL reset_char_bits: got %b expected 000000", char_bits_o); end
        tests_run++; if (word_gap_o !== 1'b0) begin tests_failed++; $display("FAIL reset_word_gap: got %0b expected 0", word_gap_o); end
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %0b expected 0", error_o); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
        rstn_i = 1'b1;
        repeat (4) @(negedge clk_i);
        $display("[TB] reset: outputs cleared, released at cycle %0d", cyc);
    endtask

    task automatic test_letter_a();
        int c0, w0, e0, p;
        c0 = cv_n; w0 = wg_n; e0 = er_n;
        key_hold(1'b1, 4);
        key_hold(1'b0, 4);
        key_hold(1'b1, 12);
        p = cyc;
        key_hold(1'b0, 40);
        $display("[TB] letter_a: released at %0d, cv=%0d wg=%0d", p, cv_n - c0, wg_n - w0);
        tests_run++; if (cv_n - c0 != 1) begin tests_failed++; $display("FAIL a_cv_count: got %0d expected 1", cv_n - c0); end
        tests_run++; if (cv_cyc[c0] != p + 13) begin tests_failed++; $display("FAIL a_cv_time: got %0d expected %0d", cv_cyc[c0], p + 13); end
        tests_run++; if (cv_len[c0] !== 3'd2) begin tests_failed++; $display("FAIL a_len: got %0d expected 2", cv_len[c0]); end
        tests_run++; if (cv_bits[c0] !== 6'b000010) begin tests_failed++; $display("FAIL a_bits: got %b expected 000010", cv_bits[c0]); end
        tests_run++; if (wg_n - w0 != 1) begin tests_failed++; $display("FAIL a_wg_count: got %0d expected 1", wg_n - w0); end
        tests_run++; if (wg_cyc[w0] != p + 25) begin tests_failed++; $display("FAIL a_wg_time: got %0d expected %0d", wg_cyc[w0], p + 25); end
        tests_run++; if (er_n != e0) begin tests_failed++; $display("FAIL a_no_error: got %0d expected 0", er_n - e0); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL a_busy_after: got %0b expected 0", busy_o); end
        tests_run++; if (char_len_o !== 3'd2) begin tests_failed++; $display("FAIL a_len_hold: got %0d expected 2", char_len_o); end
    endtask

    task automatic test_glitch();
        int c0, e0, p, busy_seen;
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            key_i = 1'b1;
            @(negedge clk_i);
            if (busy_o) busy_seen++;
            key_i = 1'b0;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk_i);
                if (busy_o) busy_seen++;
            end
        end
        tests_run++; if (busy_seen != 0) begin tests_failed++; $display("FAIL glitch_idle_busy: got %0d busy cycles expected 0", busy_seen); end
        c0 = cv_n; e0 = er_n;
        key_hold(1'b1, 4);
        key_hold(1'b0, 1);
        key_hold(1'b1, 3);
        key_hold(1'b0, 1);
        key_hold(1'b1, 3);
        p = cyc;
        key_hold(1'b0, 40);
        $display("[TB] glitch: released at %0d, cv=%0d", p, cv_n - c0);
        tests_run++; if (cv_n - c0 != 1) begin tests_failed++; $display("FAIL glitch_cv_count: got %0d expected 1", cv_n - c0); end
        tests_run++; if (cv_cyc[c0] != p + 13) begin tests_failed++; $display("FAIL glitch_cv_time: got %0d expected %0d", cv_cyc[c0], p + 13); end
        tests_run++; if (cv_len[c0] !== 3'd1) begin tests_failed++; $display("FAIL glitch_len: got %0d expected 1", cv_len[c0]); end
        tests_run++; if (cv_bits[c0] !== 6'b000001) begin tests_failed++; $display("FAIL glitch_bits: got %b expected 000001", cv_bits[c0]); end
        tests_run++; if (er_n != e0) begin tests_failed++; $display("FAIL glitch_no_error: got %0d expected 0", er_n - e0); end
    endtask

    task automatic test_overlong();
        int c0, w0, e0, p, r;
        c0 = cv_n; w0 = wg_n; e0 = er_n;
        p = cyc;
        key_hold(1'b1, 40);
        r = cyc;
        key_hold(1'b0, 40);
        $display("[TB] overlong: pressed at %0d released at %0d, err=%0d", p, r, er_n - e0);
        tests_run++; if (er_n - e0 != 1) begin tests_failed++; $display("FAIL over_err_count: got %0d expected 1", er_n - e0); end
        tests_run++; if (er_cyc[e0] != p + 37) begin tests_failed++; $display("FAIL over_err_time: got %0d expected %0d", er_cyc[e0], p + 37); end
        tests_run++; if (cv_n != c0) begin tests_failed++; $display("FAIL over_no_char: got %0d expected 0", cv_n - c0); end
        tests_run++; if (wg_n - w0 != 1) begin tests_failed++; $display("FAIL over_wg_count: got %0d expected 1", wg_n - w0); end
        tests_run++; if (wg_cyc[w0] != r + 25) begin tests_failed++; $display("FAIL over_wg_time: got %0d expected %0d", wg_cyc[w0], r + 25); end
    endtask

    task automatic test_overflow();
        int c0, w0, e0, p;
        c0 = cv_n; w0 = wg_n; e0 = er_n; p = 0;
        for (int i = 0; i < 7; i++) begin
            key_hold(1'b1, 4);
            p = cyc;
            key_hold(1'b0, 4);
        end
        key_hold(1'b0, 36);
        $display("[TB] overflow: 7th release at %0d, err=%0d cv=%0d", p, er_n - e0, cv_n - c0);
        tests_run++; if (er_n - e0 != 1) begin tests_failed++; $display("FAIL ovf_err_count: got %0d expected 1", er_n - e0); end
        tests_run++; if (er_cyc[e0] != p + 5) begin tests_failed++; $display("FAIL ovf_err_time: got %0d expected %0d", er_cyc[e0], p + 5); end
        tests_run++; if (cv_n != c0) begin tests_failed++; $display("FAIL ovf_no_char: got %0d expected 0", cv_n - c0); end
        tests_run++; if (wg_n - w0 != 1) begin tests_failed++; $display("FAIL ovf_wg_count: got %0d expected 1", wg_n - w0); end
    endtask

    task automatic test_back_to_back();
        int c0, w0, p1, p2;
        c0 = cv_n; w0 = wg_n;
        key_hold(1'b1, 4);
        p1 = cyc;
        key_hold(1'b0, 12);
        key_hold(1'b1, 12);
        p2 = cyc;
        key_hold(1'b0, 40);
        $display("[TB] back_to_back: E released %0d, T released %0d, cv=%0d", p1, p2, cv_n - c0);
        tests_run++; if (cv_n - c0 != 2) begin tests_failed++; $display("FAIL b2b_cv_count: got %0d expected 2", cv_n - c0); end
        tests_run++; if (cv_cyc[c0] != p1 + 13) begin tests_failed++; $display("FAIL b2b_e_time: got %0d expected %0d", cv_cyc[c0], p1 + 13); end
        tests_run++; if (cv_len[c0] !== 3'd1) begin tests_failed++; $display("FAIL b2b_e_len: got %0d expected 1", cv_len[c0]); end
        tests_run++; if (cv_bits[c0] !== 6'b000000) begin tests_failed++; $display("FAIL b2b_e_bits: got %b expected 000000", cv_bits[c0]); end
        tests_run++; if (cv_cyc[c0 + 1] != p2 + 13) begin tests_failed++; $display("FAIL b2b_t_time: got %0d expected %0d", cv_cyc[c0 + 1], p2 + 13); end
        tests_run++; if (cv_len[c0 + 1] !== 3'd1) begin tests_failed++; $display("FAIL b2b_t_len: got %0d expected 1", cv_len[c0 + 1]); end
        tests_run++; if (cv_bits[c0 + 1] !== 6'b000001) begin tests_failed++; $display("FAIL b2b_t_bits: got %b expected 000001", cv_bits[c0 + 1]); end
        // The only word gap must follow the second character.
        tests_run++; if (wg_n - w0 != 1) begin tests_failed++; $display("FAIL b2b_wg_count: got %0d expected 1", wg_n - w0); end
        tests_run++; if (wg_cyc[w0] != p2 + 25) begin tests_failed++; $display("FAIL b2b_wg_time: got %0d expected %0d", wg_cyc[w0], p2 + 25); end
    endtask

    task automatic test_reset_mid_mark();
        int c0, p;
        key_hold(1'b1, 8);
        tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before: got %0b expected 1", busy_o); end
        rstn_i = 1'b0;
        #1;
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %0b expected 0", busy_o); end
        tests_run++; if (char_len_o !== 3'd0) begin tests_failed++; $display("FAIL mid_len: got %0d expected 0", char_len_o); end
        tests_run++; if (char_bits_o !== 6'd0) begin tests_failed++; $display("FAIL mid_bits: got %b expected 000000", char_bits_o); end
        tests_run++; if ({char_valid_o, word_gap_o, error_o} !== 3'b000) begin tests_failed++; $display("FAIL mid_strobes: got %b expected 000", {char_valid_o, word_gap_o, error_o}); end
        key_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (4) @(negedge clk_i);
        c0 = cv_n;
        key_hold(1'b1, 4);
        p = cyc;
        key_hold(1'b0, 40);
        $display("[TB] reset_mid_mark: E released %0d, cv=%0d", p, cv_n - c0);
        tests_run++; if (cv_n - c0 != 1) begin tests_failed++; $display("FAIL mid_e_count: got %0d expected 1", cv_n - c0); end
        tests_run++; if (cv_cyc[c0] != p + 13) begin tests_failed++; $display("FAIL mid_e_time: got %0d expected %0d", cv_cyc[c0], p + 13); end
        tests_run++; if (cv_len[c0] !== 3'd1) begin tests_failed++; $display("FAIL mid_e_len: got %0d expected 1", cv_len[c0]); end
        tests_run++; if (cv_bits[c0] !== 6'b000000) begin tests_failed++; $display("FAIL mid_e_bits: got %b expected 000000", cv_bits[c0]); end
    endtask

    task automatic test_exclusive();
        tests_run++; if (excl_bad != 0) begin tests_failed++; $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", excl_bad); end
        $display("[TB] exclusive: %0d overlapping strobe cycles", excl_bad);
    endtask

    initial begin
        rstn_i = 1'b1;
        key_i  = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_letter_a();
        test_glitch();
        test_overlong();
        test_overflow();
        test_back_to_back();
        test_reset_mid_mark();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
